// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: upstream stage of the 8-bit DAC.
// Buffers sample codes from a valid/ready producer in a small FIFO. The block
// releases one code per programmable sample period (div+1 clocks) onto dac_d.
// On underflow it holds the last code and sets a sticky flag. While disabled it
// parks the DAC at IDLE_CODE.
//
// Optional feature: define DAC_FEED_SLEW_EN to slew-limit dac_d toward each
// popped sample by at most MAX_STEP per tick.
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   en          run enable; 0 flushes the FIFO and returns to IDLE
//   div         sample period minus one, sampled every cycle
//   s_data      sample code from producer
//   s_valid     producer has s_data
//   s_ready     FIFO can accept (not full)
//   dac_d       registered code to the DAC digital input
//   dac_update  one-cycle pulse: dac_d took a new value
//   underflow   sticky: a tick found no sample to consume
//   level       FIFO occupancy 0..DEPTH
module dac_sample_feeder #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DIV_W     = 16,
  parameter logic [7:0]  IDLE_CODE = 8'h80,
  parameter int unsigned MAX_STEP  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DIV_W-1:0]           div,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [7:0]                 dac_d,
  output logic                       dac_update,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned DW    = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned HALF  = DEPTH / 2;

  // Elaboration-time parameter legality checks
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dac_sample_feeder: DEPTH must be a power of 2 and >= 2");
  end
  if (MAX_STEP < 1 || MAX_STEP > 255) begin : g_bad_step
    $error("dac_sample_feeder: MAX_STEP must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DIV_W-1:0] cnt;
  logic [DW-1:0]    head;
  logic             full, empty;
  logic             push, pop, tick, uf_set;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign s_ready = !full;
  assign head    = mem[rd_ptr];

`ifdef DAC_FEED_SLEW_EN
  localparam logic signed [8:0] STEP_P = 9'(MAX_STEP);

  logic [DW-1:0]     target;
  logic [DW-1:0]     src;
  logic              at_tgt, move;
  logic signed [8:0] diff, stp;
  logic [8:0]        sum;

  assign at_tgt = (dac_d == target);

  // Step toward the (possibly freshly popped) target, clamped to +-MAX_STEP
  always_comb begin
    src  = target;
    diff = '0;
    stp  = '0;
    sum  = '0;
    move = 1'b0;
    if (pop) src = head;
    diff = $signed({1'b0, src}) - $signed({1'b0, dac_d});
    if (diff > STEP_P)       stp = STEP_P;
    else if (diff < -STEP_P) stp = -STEP_P;
    else                     stp = diff;
    // Clamped step lands between dac_d and src, so the sum stays in 0..255
    sum  = {1'b0, dac_d} + $unsigned(stp);
    move = pop || (tick && !at_tgt);
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, divider tick and FIFO handshake decode
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    push      = s_valid && s_ready && en;
    pop       = 1'b0;
    uf_set    = 1'b0;
    case (state)
      IDLE:    state_nxt = PRIME;
      PRIME:   if (level >= LVL_W'(HALF)) state_nxt = RUN;
      RUN:     tick = (cnt >= div);
      default: state_nxt = IDLE;
    endcase
`ifdef DAC_FEED_SLEW_EN
    pop    = tick && at_tgt && !empty;
    uf_set = tick && at_tgt && empty;
`else
    pop    = tick && !empty;
    uf_set = tick && empty;
`endif
    if (!en) state_nxt = IDLE;
  end

  // Sample storage; contents are don't-care while level says empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // Pointers, occupancy, divider and DAC output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      cnt        <= '0;
      dac_d      <= IDLE_CODE;
      dac_update <= 1'b0;
      underflow  <= 1'b0;
`ifdef DAC_FEED_SLEW_EN
      target     <= IDLE_CODE;
`endif
    end else if (!en) begin
      // Flush on disable, abandoning any period or slew in progress
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      cnt        <= '0;
      dac_d      <= IDLE_CODE;
      dac_update <= 1'b0;
      underflow  <= 1'b0;
`ifdef DAC_FEED_SLEW_EN
      target     <= IDLE_CODE;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (!push && pop) level <= level - LVL_W'(1);
      if (state == RUN && !tick) cnt <= cnt + DIV_W'(1);
      else                       cnt <= '0;
      if (uf_set) underflow <= 1'b1;
`ifdef DAC_FEED_SLEW_EN
      if (pop) target <= head;
      if (move) dac_d <= sum[DW-1:0];
      dac_update <= move && (sum[DW-1:0] != dac_d);
`else
      if (pop) dac_d <= head;
      dac_update <= pop;
`endif
    end
  end

endmodule
